clkdvd_prog: RTL and testbench
==============================

// Module: clkdvd_prog
// PURPOSE
//  Programmable clock-enable divider; successor to the fixed 2-bit-select divider.
//  Generates a divided square wave (out) and a one-cycle tick at each period start, all in the clk domain.
//  Divisor comes from 4 preset parameters (2-bit sel) or a DIV_W-bit custom value.
//  Divisor changes are glitch-free: applied only at a period boundary, then acknowledged.
// PARAMETERS
//  DIV_W  8   width of divisor and phase counter
//  DIV0   2   preset divisor for sel=2'b00
//  DIV1   4   preset divisor for sel=2'b01
//  DIV2   8   preset divisor for sel=2'b10
//  DIV3   16  preset divisor for sel=2'b11
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  en          in   1      run enable; low forces IDLE
//  sel         in   2      preset divisor select
//  use_custom  in   1      1: take div_custom instead of preset
//  div_custom  in   DIV_W  custom divisor N (0 = stopped)
//  load        in   1      request to adopt divisor resolved this cycle
//  load_ack    out  1      1-cycle pulse: new divisor in effect this cycle
//  out         out  1      divided wave, period N cycles, registered
//  tick        out  1      1-cycle pulse on first cycle of each period
//  phase       out  DIV_W  current phase counter value
// BEHAVIOUR
//  Reset: state=IDLE, cur_div=DIV0, pend_v=0, phase=0; out, tick, load_ack = 0.
//  Divisor resolve: use_custom ? div_custom : DIV[sel], sampled only on cycles with load=1.
//  load=1 -> pend_v<=1, pend_div<=resolved value; a new load while pending overwrites pend_div (one ack only).
//  States: IDLE, RUN.
//  IDLE: phase=0, out=0, tick=0. A pending divisor applies at the next edge (cur_div<=pend_div, load_ack=1).
//  IDLE->RUN on an edge with en=1 and effective divisor N>=1 (the pending value if one is applied that edge):
//    phase<=0, out<=1, tick<=1.
//  RUN, per edge:
//    phase==N-1 (wrap): phase<=0, tick<=1; if pending, cur_div<=pend_div, load_ack<=1,
//      and the new N is used from this phase 0 onward.
//    otherwise: phase<=phase+1, tick<=0.
//    out<= (next phase < ceil(N/2)), with N the divisor in effect for next phase. Compare in DIV_W+1 bits.
//    Odd N: high one cycle longer than low.
//  RUN->IDLE on any edge with en=0 (out, tick, phase go to 0 at that edge), or at wrap when the applied divisor is 0.
//  N=1: phase stays 0; out constantly 1; tick every cycle.
//  N=0 (custom): block stays in / returns to IDLE; out=0.
//  load_ack is never asserted without a preceding load; it is high for exactly one cycle.
//  load on the same edge as a wrap is latched, not applied; it takes effect at the following wrap.
//  rst mid-period: all state returns to reset values immediately (async); pending request is discarded.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 reset: rst=1 then release with en=1, sel=00 -> out 1,0,1,0...; tick on every 2nd cycle; phase 0,1,0,1.
//  T2 presets: sel=01/11/10 each loaded for 64 cycles -> out period 4/16/8, high 2/8/4 cycles, 1 tick per period.
//  T3 glitch-free change: running N=16, load custom 6 at phase 3 -> current period completes 16 cycles;
//     load_ack at next phase 0; then period 6, high 3.
//  T4 odd/edge divisors: custom N=5 -> high 3, low 2; N=1 -> out=1 with tick every cycle; N=0 -> out=0 and IDLE.
//  T5 double load: loads of 4 then 10 within one N=16 period -> single load_ack; resulting period 10.
//  T6 en/rst mid-period: en=0 at phase 5 -> out=0 next edge; re-enable -> tick + out=1 on the first edge;
//     rst pulse mid-period -> cur_div=DIV0, pending cleared, no load_ack.

Source files
------------

// File: rtl/clkdvd_prog.sv
// Programmable clock-enable divider.
// Produces a divided square wave and a start-of-period tick in the clk domain. The divisor is
// either one of four presets or a custom value. A requested divisor is held pending and only
// adopted at a period boundary (or immediately while idle), so the output never glitches.
module clkdvd_prog #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DIV0  = 2,
  parameter int unsigned DIV1  = 4,
  parameter int unsigned DIV2  = 8,
  parameter int unsigned DIV3  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             use_custom,
  input  logic [DIV_W-1:0] div_custom,
  input  logic             load,
  output logic             load_ack,
  output logic             out,
  output logic             tick,
  output logic [DIV_W-1:0] phase
);

  localparam logic [DIV_W:0]   OneW = (DIV_W+1)'(1);
  localparam logic [DIV_W-1:0] Zero = '0;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_v;

  logic [DIV_W-1:0] res_div;
  logic [DIV_W-1:0] eff_div;
  logic             wrap;
  logic [DIV_W:0]   nxt_phase;
  logic [DIV_W-1:0] nxt_div;
  logic [DIV_W:0]   half_div;
  logic             nxt_out;

  // Resolve the requested divisor from preset select or custom value.
  always_comb begin
    res_div = DIV_W'(DIV0);
    if (use_custom) begin
      res_div = div_custom;
    end else begin
      unique case (sel)
        2'b00:   res_div = DIV_W'(DIV0);
        2'b01:   res_div = DIV_W'(DIV1);
        2'b10:   res_div = DIV_W'(DIV2);
        default: res_div = DIV_W'(DIV3);
      endcase
    end
  end

  // Next-phase arithmetic, done one bit wider so N = 2**DIV_W - 1 cannot overflow.
  always_comb begin
    eff_div   = pend_v ? pend_div : cur_div;
    wrap      = (({1'b0, phase} + OneW) == {1'b0, cur_div});
    nxt_phase = wrap ? '0 : ({1'b0, phase} + OneW);
    // At a wrap the pending divisor (if any) governs the new period from phase 0.
    nxt_div   = wrap ? eff_div : cur_div;
    half_div  = ({1'b0, nxt_div} + OneW) >> 1;
    nxt_out   = (nxt_phase < half_div);
  end

  // Divider FSM with registered outputs and pending-divisor handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      cur_div  <= DIV_W'(DIV0);
      pend_div <= Zero;
      pend_v   <= 1'b0;
      phase    <= Zero;
      out      <= 1'b0;
      tick     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      case (state)
        StIdle: begin
          phase <= Zero;
          out   <= 1'b0;
          tick  <= 1'b0;
          if (pend_v) begin
            cur_div  <= pend_div;
            pend_v   <= 1'b0;
            load_ack <= 1'b1;
          end
          if (en && (eff_div != Zero)) begin
            state <= StRun;
            out   <= 1'b1;
            tick  <= 1'b1;
          end
        end
        default: begin
          if (!en) begin
            state <= StIdle;
            phase <= Zero;
            out   <= 1'b0;
            tick  <= 1'b0;
          end else if (wrap) begin
            phase <= Zero;
            if (pend_v) begin
              cur_div  <= pend_div;
              pend_v   <= 1'b0;
              load_ack <= 1'b1;
            end
            if (eff_div == Zero) begin
              // Custom divisor 0 stops the divider.
              state <= StIdle;
              out   <= 1'b0;
              tick  <= 1'b0;
            end else begin
              out  <= nxt_out;
              tick <= 1'b1;
            end
          end else begin
            phase <= nxt_phase[DIV_W-1:0];
            out   <= nxt_out;
            tick  <= 1'b0;
          end
        end
      endcase
      // A load on this edge is only latched; a previously pending value may be applied above.
      if (load) begin
        pend_v   <= 1'b1;
        pend_div <= res_div;
      end
    end
  end

endmodule

// File: tb/tb_clkdvd_prog.sv
// Directed bench for clkdvd_prog: presets, custom/odd/edge divisors, glitch-free change,
// double load, enable drop and asynchronous reset.
module tb_clkdvd_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic       use_custom;
  logic [7:0] div_custom;
  logic       load;
  logic       load_ack;
  logic       out;
  logic       tick;
  logic [7:0] phase;

  int vectors;
  int miscompares;

  clkdvd_prog #(
    .DIV_W(8),
    .DIV0 (2),
    .DIV1 (4),
    .DIV2 (8),
    .DIV3 (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sel       (sel),
    .use_custom(use_custom),
    .div_custom(div_custom),
    .load      (load),
    .load_ack  (load_ack),
    .out       (out),
    .tick      (tick),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load request.
  task automatic do_load(input logic cust, input logic [1:0] s, input logic [7:0] dc);
    use_custom = cust;
    sel        = s;
    div_custom = dc;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  // Wait (bounded) for load_ack; then phase must be 0 and tick as given.
  task automatic wait_ack(input string tag, input logic exp_tick);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (load_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_ack_tick"}, 32'(tick), 32'(exp_tick));
    check({tag, "_ack_phase"}, 32'(phase), 32'd0);
  endtask

  // Called just after a tick edge; measures that period and stops on the next tick edge.
  task automatic measure(input string tag, input int exp_n, input int exp_high);
    int n;
    int high;
    int acks;
    logic done;
    n    = 1;
    high = int'(out);
    acks = 0;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tick) begin
        done = 1'b1;
        break;
      end
      n++;
      high += int'(out);
      acks += int'(load_ack);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_period"}, 32'(n), 32'(exp_n));
    check({tag, "_high"}, 32'(high), 32'(exp_high));
    check({tag, "_no_ack"}, 32'(acks), 32'd0);
  endtask

  initial begin
    int cnt;
    int acks;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    en          = 1'b1;
    sel         = 2'b00;
    use_custom  = 1'b0;
    div_custom  = 8'd0;
    load        = 1'b0;

    // T1: reset state, then divide by DIV0 = 2
    step();
    step();
    check("rst_out", 32'(out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_out", 32'(out), 32'(i % 2 == 0));
      check("t1_tick", 32'(tick), 32'(i % 2 == 0));
      check("t1_phase", 32'(phase), 32'(i % 2));
    end

    // T2: presets
    do_load(1'b0, 2'b01, 8'd0);
    wait_ack("t2_sel1", 1'b1);
    for (int i = 0; i < 3; i++) measure("t2_div4", 4, 2);
    do_load(1'b0, 2'b11, 8'd0);
    wait_ack("t2_sel3", 1'b1);
    for (int i = 0; i < 2; i++) measure("t2_div16", 16, 8);
    do_load(1'b0, 2'b10, 8'd0);
    wait_ack("t2_sel2", 1'b1);
    for (int i = 0; i < 3; i++) measure("t2_div8", 8, 4);

    // T3: change 16 -> 6 requested at phase 3
    do_load(1'b0, 2'b11, 8'd0);
    wait_ack("t3_sel3", 1'b1);
    step();
    step();
    step();
    check("t3_phase3", 32'(phase), 32'd3);
    do_load(1'b1, 2'b00, 8'd6);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt++;
      if (load_ack) break;
    end
    check("t3_ack_delay", 32'(cnt), 32'd12);
    check("t3_ack_tick", 32'(tick), 32'd1);
    check("t3_ack_phase", 32'(phase), 32'd0);
    measure("t3_div6", 6, 3);

    // T4: odd and edge divisors
    do_load(1'b1, 2'b00, 8'd5);
    wait_ack("t4_n5", 1'b1);
    measure("t4_div5a", 5, 3);
    measure("t4_div5b", 5, 3);
    do_load(1'b1, 2'b00, 8'd1);
    wait_ack("t4_n1", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_n1_out", 32'(out), 32'd1);
      check("t4_n1_tick", 32'(tick), 32'd1);
      check("t4_n1_phase", 32'(phase), 32'd0);
    end
    do_load(1'b1, 2'b00, 8'd0);
    check("t4_n0_latched_no_ack", 32'(load_ack), 32'd0);
    wait_ack("t4_n0", 1'b0);
    check("t4_n0_out", 32'(out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_idle_out", 32'(out), 32'd0);
      check("t4_idle_tick", 32'(tick), 32'd0);
    end
    do_load(1'b1, 2'b00, 8'd3);
    check("t4_idle_latch_out", 32'(out), 32'd0);
    wait_ack("t4_n3", 1'b1);
    check("t4_n3_start_out", 32'(out), 32'd1);
    measure("t4_div3", 3, 2);

    // T5: two loads within one N=16 period -> one ack, last value wins
    do_load(1'b0, 2'b11, 8'd0);
    wait_ack("t5_sel3", 1'b1);
    step();
    step();
    do_load(1'b1, 2'b00, 8'd4);
    step();
    step();
    step();
    do_load(1'b1, 2'b00, 8'd10);
    check("t5_phase7", 32'(phase), 32'd7);
    wait_ack("t5_n10", 1'b1);
    measure("t5_div10a", 10, 5);
    measure("t5_div10b", 10, 5);

    // T6: enable drop mid-period, re-enable, async reset with a pending load
    for (int i = 0; i < 5; i++) step();
    check("t6_phase5", 32'(phase), 32'd5);
    en = 1'b0;
    step();
    check("t6_off_out", 32'(out), 32'd0);
    check("t6_off_tick", 32'(tick), 32'd0);
    check("t6_off_phase", 32'(phase), 32'd0);
    step();
    check("t6_off2_out", 32'(out), 32'd0);
    en = 1'b1;
    step();
    check("t6_on_tick", 32'(tick), 32'd1);
    check("t6_on_out", 32'(out), 32'd1);
    check("t6_on_phase", 32'(phase), 32'd0);
    do_load(1'b1, 2'b00, 8'd6);
    step();
    check("t6_pre_rst_phase", 32'(phase), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out", 32'(out), 32'd0);
    check("t6_rst_tick", 32'(tick), 32'd0);
    check("t6_rst_phase", 32'(phase), 32'd0);
    check("t6_rst_ack", 32'(load_ack), 32'd0);
    use_custom = 1'b0;
    sel        = 2'b00;
    #2 rst = 1'b0;
    step();
    check("t6_restart_tick", 32'(tick), 32'd1);
    check("t6_restart_out", 32'(out), 32'd1);
    check("t6_restart_ack", 32'(load_ack), 32'd0);
    measure("t6_div2a", 2, 1);
    measure("t6_div2b", 2, 1);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acks += int'(load_ack);
    end
    check("t6_no_ack_after_rst", 32'(acks), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
